// File: rtl/seq_divider.sv
//==============================================================================
// Module   : seq_divider
// Brief    : Iterative non-restoring divider, one quotient bit per clock,
//            unsigned or two's-complement operands, with divide-by-zero flag.
// Revision : 1.0
//==============================================================================
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_p;        // partial remainder, MSB is its sign
  logic [WIDTH-1:0] r_q;        // quotient shift register (raw dividend on /0)
  logic [WIDTH-1:0] r_d;        // divisor magnitude
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz_pend;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;
  logic             r_dbz;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dext;
  logic [WIDTH:0]   w_p_step;
  logic [WIDTH:0]   w_p_fix;
  logic [WIDTH-1:0] w_rem_mag;

  // A start coinciding with the done pulse is deliberately dropped.
  assign w_accept   = (r_state == S_IDLE) && start && !r_done;
  assign w_a_neg    = signed_mode & dividend[WIDTH-1];
  assign w_b_neg    = signed_mode & divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -dividend : dividend;
  assign w_b_mag    = w_b_neg ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);

  assign w_shift    = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_dext     = {1'b0, r_d};
  assign w_p_step   = r_p[WIDTH] ? (w_shift + w_dext) : (w_shift - w_dext);
  assign w_p_fix    = r_p[WIDTH] ? (r_p + w_dext) : r_p;
  assign w_rem_mag  = w_p_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_div_zero ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_CORR;
      S_CORR: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_p        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dbz_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_d        <= w_b_mag;
            r_p        <= '0;
            r_cnt      <= w_div_zero ? '0 : CNT_W'(WIDTH);
            r_dbz_pend <= w_div_zero;
            r_q        <= w_div_zero ? dividend : w_a_mag;
          end
        end
        S_CALC: begin
          r_p   <= w_p_step;
          r_q   <= {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_CORR: begin
          r_p <= {1'b0, (r_r_neg ? -w_rem_mag : w_rem_mag)};
          r_q <= r_q_neg ? -r_q : r_q;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_quot <= r_dbz_pend ? '1  : r_q;
        r_rem  <= r_dbz_pend ? r_q : r_p[WIDTH-1:0];
        r_dbz  <= r_dbz_pend;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//==============================================================================
// Module   : tb_seq_divider
// Brief    : Self-checking bench for seq_divider against an arithmetic model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;
  logic         hold_dz = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sm, output logic [W-1:0] q,
                                output logic [W-1:0] r, output logic dz);
    longint sa, sb, lq, lr;
    dz = 1'b0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (!sm) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  // Caller sits mid-cycle; the next rising edge is the start edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input bit inject, input bit check_pulse, input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    int           edges, busy_cnt, exp_lat;
    bit           stable;
    model(a, b, sm, eq, er, edz);
    exp_lat = (b == '0) ? 1 : W + 2;
    stable = 1'b1;
    signed_mode = sm; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_mode = 1'($urandom);
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 200) begin
      if (quotient !== hold_q || remainder !== hold_r || div_by_zero !== hold_dz) stable = 1'b0;
      if (inject && (edges == 4 || edges == 32)) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(0, 3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (!done && busy) busy_cnt++;
    end
    start = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL %s timeout: done not seen within %0d edges", tag, edges);
    end
    n_cmp++;
    if (edges !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d edges expected %0d", tag, edges, exp_lat);
    end
    n_cmp++;
    if (busy_cnt !== exp_lat) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, exp_lat);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL %s busy_at_done: got %b expected 0", tag, busy);
    end
    n_cmp++;
    if (quotient !== eq) begin
      n_bad++; $display("FAIL %s quotient: got %h expected %h", tag, quotient, eq);
    end
    n_cmp++;
    if (remainder !== er) begin
      n_bad++; $display("FAIL %s remainder: got %h expected %h", tag, remainder, er);
    end
    n_cmp++;
    if (div_by_zero !== edz) begin
      n_bad++; $display("FAIL %s div_by_zero: got %b expected %b", tag, div_by_zero, edz);
    end
    n_cmp++;
    if (!stable) begin
      n_bad++; $display("FAIL %s stability: outputs moved before done, got 0 expected 1", tag);
    end
    hold_q = eq; hold_r = er; hold_dz = edz;
    if (check_pulse) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++; $display("FAIL %s done_pulse: got %b expected 0", tag, done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL reset done: got %b expected 0", done); end
    n_cmp++; if (quotient !== '0)      begin n_bad++; $display("FAIL reset quotient: got %h expected 0", quotient); end
    n_cmp++; if (remainder !== '0)     begin n_bad++; $display("FAIL reset remainder: got %h expected 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset div_by_zero: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    hold_q = '0; hold_r = '0; hold_dz = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, "u100_7");
    run_div(-32'sd100, 32'd7, 1'b1, 1'b0, 1'b1, "s-100_7");
    run_div(32'd100, -32'sd7, 1'b1, 1'b0, 1'b1, "s100_-7");
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1, "uffff_2");
    run_div(-32'sd100, -32'sd7, 1'b1, 1'b0, 1'b1, "s-100_-7");
  endtask

  task automatic test_div_by_zero();
    run_div(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1, "dbz_u");
    run_div(32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b1, "dbz_s");
    run_div(32'd50, 32'd5, 1'b0, 1'b0, 1'b1, "dbz_clear");
  endtask

  task automatic test_overflow();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, "ovf_s");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "ovf_u");
  endtask

  task automatic test_ignore_start();
    run_div(32'd1000, 32'd33, 1'b0, 1'b1, 1'b1, "ignore");
  endtask

  task automatic test_back_to_back();
    run_div(32'd999, 32'd10, 1'b0, 1'b0, 1'b0, "b2b_first");
    start = 1'b1; dividend = 32'd77; divisor = 32'd0;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_ignored: got done=%b busy=%b expected 0 0", done, busy);
    end
    run_div(-32'sd12345, 32'd123, 1'b1, 1'b0, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    bit seen;
    signed_mode = 1'b0; dividend = 32'd5000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_q = '0; hold_r = '0; hold_dz = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL mid_reset_no_done: got activity 1 expected 0");
    end
    run_div(32'd5000, 32'd3, 1'b0, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         sm;
    int           sel;
    for (int i = 0; i < 40; i++) begin
      sm  = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = '0;
      else if (sel <= 3) b = W'($urandom_range(1, 20));
      else if (sel == 4) b = '1;
      else               b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_div(a, b, sm, 1'b0, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
